serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 22 ++
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/serial_subtractor_full_subtractor_cell.sv | 15 +
 rtl/serial_subtractor.sv | 91 +++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_subtractor_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = IDLE,
      StRun  = RUN,
      StDone = DONE
   } state_e;

   // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle between a controller and the serial subtractor.
//   start, in1, in2, borrow_in : request and operands (controller -> subtractor)
//   busy, done                 : status (subtractor -> controller)
//   diff, borrow_out, overflow : registered result (subtractor -> controller)
interface serial_subtractor_if import serial_subtractor_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;

   modport master (
      output start, in1, in2, borrow_in,
      input  busy, done, diff, borrow_out, overflow
   );

   modport slave (
      input  start, in1, in2, borrow_in,
      output busy, done, diff, borrow_out, overflow
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = in1 - in2 - borrow_in, one bit per clock,
// LSB first, through a single reused full-subtractor cell.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : slave side of serial_subtractor_if (start/operands in,
//         busy/done/diff/borrow_out/overflow out)
module serial_subtractor import serial_subtractor_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CntW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, work_q, work_d, diff_q;
   logic             br_q, borrow_out_q, overflow_q;
   logic [CntW-1:0]  cnt_q;
   logic             cell_d, cell_bout;
   logic             load, last;

   full_subtractor_cell u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (br_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // Operands are accepted from both IDLE and DONE, giving back-to-back issue.
   assign load   = (state_q != StRun) && bus.start;
   assign last   = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));
   assign work_d = {cell_d, work_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StRun;
         StRun:   if (last) state_d = StDone;
         StDone:  state_d = bus.start ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         br_q         <= 1'b0;
         work_q       <= '0;
         cnt_q        <= '0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else if (load) begin
         a_q   <= bus.in1;
         b_q   <= bus.in2;
         br_q  <= bus.borrow_in;
         cnt_q <= '0;
      end else if (state_q == StRun) begin
         a_q    <= a_q >> 1;
         b_q    <= b_q >> 1;
         br_q   <= cell_bout;
         work_q <= work_d;
         cnt_q  <= cnt_q + CntW'(1);
         // Results are published only once the MSB has been processed.
         if (last) begin
            diff_q       <= work_d;
            borrow_out_q <= cell_bout;
            overflow_q   <= br_q ^ cell_bout;
         end
      end
   end

   assign bus.busy       = (state_q == StRun);
   assign bus.done       = (state_q == StDone);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_out_q;
   assign bus.overflow   = overflow_q;

endmodule
